// File: rtl/mem_byte_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mem_byte_sequencer_pkg
// Shared types and helpers for the byte-serial data memory sequencer:
//   size_e      : CPU access size encoding (byte / half / word, 2'b11 = word)
//   state_e     : sequencer FSM state encoding
//   beat_count  : number of single-byte memory beats for an access size
//   is_misaligned : natural-alignment check for an access size and address
// -----------------------------------------------------------------------------
package mem_byte_sequencer_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE     = 2'b00,
        SZ_HALF     = 2'b01,
        SZ_WORD     = 2'b10,
        SZ_WORD_ALT = 2'b11   // reserved code, behaves as a word
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10
    } state_e;

    // Number of byte beats (1, 2 or 4) needed for one CPU access.
    function automatic logic [2:0] beat_count(input size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Halfwords want addr[0]==0, words want addr[1:0]==0; bytes are always aligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_sequencer_if.sv
// -----------------------------------------------------------------------------
// mem_byte_sequencer_if
// Byte-wide data memory bus between the sequencer and the data memory.
//   we    : byte write enable (sampled by memory on rising clock edge)
//   re    : read enable
//   addr  : byte address, ADDR_W bits
//   wdata : write byte
//   rdata : read byte, combinational from addr
// Modports: master = sequencer, slave = data memory.
// -----------------------------------------------------------------------------
interface mem_byte_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
    logic [7:0]        rdata;

    modport master (output we, re, addr, wdata, input rdata);
    modport slave  (input we, re, addr, wdata, output rdata);
endinterface

// File: rtl/mem_load_extend.sv
// -----------------------------------------------------------------------------
// mem_load_extend
// Combinational load-data extension for the writeback path.
//   data     : assembled little-endian load bytes (upper lanes may be junk)
//   size     : access size; byte/half are extended from bit 7/15, word passes
//   zero_ext : 1 = zero-extend, 0 = sign-extend
//   result   : extended 32-bit load value
// -----------------------------------------------------------------------------
module mem_load_extend
    import mem_byte_sequencer_pkg::*;
(
    input  logic [31:0] data,
    input  size_e       size,
    input  logic        zero_ext,
    output logic [31:0] result
);

    always_comb begin
        case (size)
            SZ_BYTE: result = zero_ext ? {24'h000000, data[7:0]}
                                       : {{24{data[7]}}, data[7:0]};
            SZ_HALF: result = zero_ext ? {16'h0000, data[15:0]}
                                       : {{16{data[15]}}, data[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/mem_byte_sequencer.sv
// -----------------------------------------------------------------------------
// mem_byte_sequencer
// Splits one CPU load/store (byte, half, word) into 1/2/4 little-endian
// single-byte transactions on a 32 x 8 data memory, stalling the pipeline
// until done, then presents the extended load data for one DONE cycle.
//
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   mem_read_i/mem_write_i: load/store request (both set = store)
//   size_i, unsigned_i    : access size, zero-extend select for loads
//   addr_i, wdata_i       : byte address, store data (low bytes for byte/half)
//   stall_o               : hold the upstream pipeline registers
//   done_o                : one-cycle completion pulse
//   rdata_o               : extended load data (0 for stores), held until next done
//   misalign_o, oob_o     : check flags, valid with done_o
//   dm                    : byte-wide data memory bus (master side)
//
// Build option: define MEM_BYTE_FASTPATH_EN to complete byte-size requests
// combinationally in the IDLE cycle (no stall, no state change).
// -----------------------------------------------------------------------------
module mem_byte_sequencer
    import mem_byte_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [1:0]           size_i,
    input  logic                 unsigned_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 stall_o,
    output logic                 done_o,
    output logic [31:0]          rdata_o,
    output logic                 misalign_o,
    output logic                 oob_o,
    mem_byte_sequencer_if.master dm
);

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(MEM_BYTES);

    // Latched request and progress.
    state_e            state;
    logic [1:0]        beat;
    size_e             size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              store_q;
    logic [31:0]       asm_q;
    logic              mis_q;
    logic              oob_acc;

    // Registered completion outputs.
    logic              done_q;
    logic              mis_out_q;
    logic              oob_out_q;
    logic [31:0]       rdata_q;

    logic              req;
    logic [ADDR_W-1:0] beat_addr;
    logic              last_beat;
    logic              dm_in_range;
    logic [7:0]        rd_lane;
    logic [31:0]       next_asm;
    logic              fast_hit;
    logic [31:0]       ext_data;
    size_e             ext_size;
    logic              ext_uns;
    logic [31:0]       ext_result;
    logic [31:0]       fast_rdata;

    assign req       = mem_read_i | mem_write_i;
    // Wraps modulo 2^ADDR_W by construction of the adder width.
    assign beat_addr = addr_q + ADDR_W'(beat);
    assign last_beat = ({1'b0, beat} == (beat_count(size_q) - 3'd1));

`ifdef MEM_BYTE_FASTPATH_EN
    logic fast_in_range;
    assign fast_hit      = (state == S_IDLE) && req && !rst_i && (size_e'(size_i) == SZ_BYTE);
    assign fast_in_range = addr_i < LIMIT;
`else
    assign fast_hit = 1'b0;
`endif

    // Memory bus drive: sequenced beats in ACCESS, or the direct byte path.
    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dm.we       = 1'b0;
        dm.re       = 1'b0;
        dm.addr     = '0;
        dm.wdata    = 8'h00;
        dm_in_range = 1'b0;
        if (state == S_ACCESS) begin
            dm_in_range = beat_addr < LIMIT;
            dm.addr     = beat_addr;
            dm.wdata    = wdata_q[{beat, 3'b000} +: 8];
            dm.we       = store_q & dm_in_range;
            dm.re       = ~store_q;
        end
`ifdef MEM_BYTE_FASTPATH_EN
        else if (fast_hit) begin
            dm_in_range = fast_in_range;
            dm.addr     = addr_i;
            dm.wdata    = wdata_i[7:0];
            dm.we       = mem_write_i & fast_in_range;
            dm.re       = ~mem_write_i;
        end
`endif
    end

    // Out-of-range beats contribute a zero lane instead of whatever the bus returns.
    assign rd_lane = dm_in_range ? dm.rdata : 8'h00;

    always_comb begin
        next_asm = asm_q;
        next_asm[{beat, 3'b000} +: 8] = rd_lane;
    end

    // One extender serves both the sequenced completion and the direct byte path.
    assign ext_data = fast_hit ? {24'h000000, rd_lane} : next_asm;
    assign ext_size = fast_hit ? SZ_BYTE : size_q;
    assign ext_uns  = fast_hit ? unsigned_i : uns_q;

    mem_load_extend u_extend (
        .data     (ext_data),
        .size     (ext_size),
        .zero_ext (ext_uns),
        .result   (ext_result)
    );

    assign fast_rdata = mem_write_i ? 32'h0 : ext_result;

    // Upstream stalls from the accepting cycle through the last beat; reset
    // forces every output low even with a request present.
    assign stall_o    = (state == S_ACCESS) ||
                        ((state == S_IDLE) && req && !rst_i && !fast_hit);
    assign done_o     = done_q | fast_hit;
    assign rdata_o    = fast_hit ? fast_rdata : rdata_q;
    assign misalign_o = mis_out_q;
`ifdef MEM_BYTE_FASTPATH_EN
    assign oob_o      = oob_out_q | (fast_hit & ~fast_in_range);
`else
    assign oob_o      = oob_out_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values and ordering between blocks cannot matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= S_IDLE;
            beat      <= 2'd0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            store_q   <= 1'b0;
            asm_q     <= 32'h0;
            mis_q     <= 1'b0;
            oob_acc   <= 1'b0;
            done_q    <= 1'b0;
            mis_out_q <= 1'b0;
            oob_out_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            // Completion flags are single-cycle pulses.
            done_q    <= 1'b0;
            mis_out_q <= 1'b0;
            oob_out_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fast_hit) begin
                        rdata_q <= fast_rdata;
                    end else if (req) begin
                        size_q  <= size_e'(size_i);
                        uns_q   <= unsigned_i;
                        addr_q  <= addr_i;
                        wdata_q <= wdata_i;
                        store_q <= mem_write_i;
                        mis_q   <= is_misaligned(size_e'(size_i), addr_i[1:0]);
                        asm_q   <= 32'h0;
                        oob_acc <= 1'b0;
                        beat    <= 2'd0;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    asm_q   <= next_asm;
                    oob_acc <= oob_acc | ~dm_in_range;
                    beat    <= beat + 2'd1;
                    if (last_beat) begin
                        // Results are registered here so they are stable
                        // throughout DONE and held afterwards.
                        state     <= S_DONE;
                        done_q    <= 1'b1;
                        mis_out_q <= mis_q;
                        oob_out_q <= oob_acc | ~dm_in_range;
                        rdata_q   <= store_q ? 32'h0 : ext_result;
                    end
                end
                S_DONE: begin
                    // The request still present now is the one just finished.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mem_byte_sequencer
// Self-checking bench: a 32 x 8 data memory model on the slave side of the
// bus, and a transaction-level reference (byte array + arithmetic) giving the
// expected memory image, load value, flags and stall length for each access.
// Honours MEM_BYTE_FASTPATH_EN for the expected byte-access latency.
// -----------------------------------------------------------------------------
module tb_mem_byte_sequencer;

    localparam int ADDR_W    = 32;
    localparam int MEM_BYTES = 32;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        mem_read_i  = 1'b0;
    logic        mem_write_i = 1'b0;
    logic [1:0]  size_i      = 2'b00;
    logic        unsigned_i  = 1'b0;
    logic [31:0] addr_i      = 32'h0;
    logic [31:0] wdata_i     = 32'h0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        oob_o;

    mem_byte_sequencer_if #(.ADDR_W(ADDR_W)) dm_bus ();

    mem_byte_sequencer #(
        .ADDR_W    (ADDR_W),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .size_i      (size_i),
        .unsigned_i  (unsigned_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .misalign_o  (misalign_o),
        .oob_o       (oob_o),
        .dm          (dm_bus)
    );

    always #5 clk_i = ~clk_i;

    // Data memory model: write on rising edge, combinational read. Addresses
    // past the array return a junk pattern that must never reach a load lane.
    logic [7:0] dmem    [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic       pre_en   = 1'b0;
    logic [4:0] pre_addr = 5'd0;
    logic [7:0] pre_data = 8'h00;

    always @(posedge clk_i) begin
        if (pre_en)
            dmem[pre_addr] <= pre_data;
        else if (dm_bus.we && dm_bus.addr < 32'(MEM_BYTES))
            dmem[dm_bus.addr[4:0]] <= dm_bus.wdata;
    end

    assign dm_bus.rdata = (dm_bus.addr < 32'(MEM_BYTES)) ? dmem[dm_bus.addr[4:0]] : 8'hA5;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < MEM_BYTES; i++)
            check($sformatf("%s_mem%0d", tag, i), 32'(dmem[i]), 32'(ref_mem[i]));
    endtask

    // Reference: walk the N little-endian byte addresses of the access.
    task automatic model_access(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output int exp_stall, output logic [31:0] exp_rdata,
                                output logic exp_mis, output logic exp_oob);
        int          n;
        logic [31:0] v;
        logic [31:0] ba;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        v = 32'h0;
        exp_oob = 1'b0;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if (ba >= 32'(MEM_BYTES))
                exp_oob = 1'b1;
            else if (wr)
                ref_mem[ba[4:0]] = wd[8*i +: 8];
            else
                v = v + (32'(ref_mem[ba[4:0]]) << (8 * i));
        end
        if (wr)                 exp_rdata = 32'h0;
        else if (n == 4 || uns) exp_rdata = v;
        else if (n == 1)        exp_rdata = (v >= 32'd128)   ? v + 32'hFFFF_FF00 : v;
        else                    exp_rdata = (v >= 32'd32768) ? v + 32'hFFFF_0000 : v;
        exp_mis = (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`ifdef MEM_BYTE_FASTPATH_EN
        exp_stall = (n == 1) ? 0 : n + 1;
`else
        exp_stall = n + 1;
`endif
    endtask

    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [1:0] sz, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] got_rdata);
        int          exp_stall;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_oob;
        int          stalls;
        int          cycles;
        logic        got;
        logic        re_seen;
        logic        mis_s;
        logic        oob_s;
        logic        stall_s;
        model_access(wr, sz, uns, a, wd, exp_stall, exp_rdata, exp_mis, exp_oob);
        @(negedge clk_i);
        mem_read_i  = rd;
        mem_write_i = wr;
        size_i      = sz;
        unsigned_i  = uns;
        addr_i      = a;
        wdata_i     = wd;
        #1;
        stalls = 0; cycles = 0; got = 1'b0; re_seen = 1'b0;
        got_rdata = 32'h0; mis_s = 1'b0; oob_s = 1'b0; stall_s = 1'b1;
        while (!got && cycles < 20) begin
            re_seen = re_seen | dm_bus.re;
            if (done_o) begin
                got       = 1'b1;
                got_rdata = rdata_o;
                mis_s     = misalign_o;
                oob_s     = oob_o;
                stall_s   = stall_o;
            end else begin
                if (stall_o) stalls++;
                cycles++;
                @(negedge clk_i);
                #1;
            end
        end
        check({tag, "_done"},         32'(got),     32'd1);
        check({tag, "_stall_cycles"}, 32'(stalls),  32'(exp_stall));
        check({tag, "_stall_at_done"},32'(stall_s), 32'd0);
        check({tag, "_rdata"},        got_rdata,    exp_rdata);
        check({tag, "_misalign"},     32'(mis_s),   32'(exp_mis));
        check({tag, "_oob"},          32'(oob_s),   32'(exp_oob));
        check({tag, "_read_en"},      32'(re_seen), 32'(rd & ~wr));
        // Pipeline advances on this edge; drop the request after it.
        @(posedge clk_i);
        #1;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        @(negedge clk_i);
        check({tag, "_rdata_hold"}, rdata_o,       exp_rdata);
        check({tag, "_done_after"}, 32'(done_o),   32'd0);
        check({tag, "_idle_stall"}, 32'(stall_o),  32'd0);
        check_mem(tag);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        rd;
        logic        wr;
        int          k;

        // Preload memory while reset holds the sequencer idle.
        for (int i = 0; i < MEM_BYTES; i++) begin
            @(negedge clk_i);
            pre_en     = 1'b1;
            pre_addr   = 5'(i);
            pre_data   = 8'($urandom);
            ref_mem[i] = pre_data;
        end
        @(negedge clk_i);
        pre_en = 1'b0;
        check("rst_stall",    32'(stall_o),      32'd0);
        check("rst_done",     32'(done_o),       32'd0);
        check("rst_rdata",    rdata_o,           32'd0);
        check("rst_misalign", 32'(misalign_o),   32'd0);
        check("rst_oob",      32'(oob_o),        32'd0);
        check("rst_dm_we",    32'(dm_bus.we),    32'd0);
        check("rst_dm_re",    32'(dm_bus.re),    32'd0);
        mem_read_i = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall_o), 32'd0);
        check("rst_done_req",  32'(done_o),  32'd0);
        mem_read_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        check_mem("preload");

        // Aligned word store, then its bytes in memory order.
        run_access("wstore", 1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, r);
        check("wstore_b8",  32'(dmem[8]),  32'hEF);
        check("wstore_b9",  32'(dmem[9]),  32'hBE);
        check("wstore_b10", 32'(dmem[10]), 32'hAD);
        check("wstore_b11", 32'(dmem[11]), 32'hDE);

        // Halfword at 0x0A holding BE, AD: signed then unsigned.
        run_access("hstore",  1'b0, 1'b1, 2'b01, 1'b0, 32'h0A, 32'h0000ADBE, r);
        run_access("hload_s", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0A, 32'h0, r);
        check("hload_s_val", r, 32'hFFFFADBE);
        run_access("hload_u", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0A, 32'h0, r);
        check("hload_u_val", r, 32'h0000ADBE);

        // Misaligned word load, out-of-range store/load, address wrap, both set.
        run_access("mwload",   1'b1, 1'b0, 2'b10, 1'b0, 32'h09, 32'h0, r);
        run_access("oobstore", 1'b0, 1'b1, 2'b10, 1'b0, 32'h1E, 32'h11223344, r);
        check("oobstore_b1e", 32'(dmem[30]), 32'h44);
        check("oobstore_b1f", 32'(dmem[31]), 32'h33);
        run_access("oobload",  1'b1, 1'b0, 2'b11, 1'b0, 32'h1E, 32'h0, r);
        run_access("wrapload", 1'b1, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFF, 32'h0, r);
        run_access("both",     1'b1, 1'b1, 2'b01, 1'b0, 32'h04, 32'h0000CAFE, r);

        // Reset during beat 1 of a word store to 0x00.
        @(negedge clk_i);
        mem_write_i = 1'b1;
        size_i      = 2'b10;
        addr_i      = 32'h0;
        wdata_i     = 32'h44332211;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("rstmid_we_before", 32'(dm_bus.we), 32'd1);
        check("rstmid_addr",      dm_bus.addr,    32'd1);
        rst_i = 1'b1;
        #1;
        check("rstmid_we",    32'(dm_bus.we), 32'd0);
        check("rstmid_stall", 32'(stall_o),   32'd0);
        check("rstmid_done",  32'(done_o),    32'd0);
        mem_write_i = 1'b0;
        @(negedge clk_i);
        check("rstmid_done_later", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        ref_mem[0] = 8'h11;
        check_mem("rstmid");
        run_access("after_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, r);

        // Byte 0x80 at 0x03, signed load.
        run_access("bstore", 1'b0, 1'b1, 2'b00, 1'b0, 32'h03, 32'h00000080, r);
        run_access("bload",  1'b1, 1'b0, 2'b00, 1'b0, 32'h03, 32'h0, r);
        check("bload_val", r, 32'hFFFFFF80);

        // Random traffic against the reference.
        repeat (40) begin
            k  = int'($urandom_range(0, 2));
            rd = (k != 1);
            wr = (k != 0);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)
                a = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
            else
                a = 32'($urandom_range(0, 35));
            run_access("rand", rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
